seven_seg_scan_display: RTL and testbench

//  Parametrised successor to the 4-digit ALU display path. Takes a binary value
//  (unsigned or two's-complement), converts it to BCD with a sequential

---
 rtl/seven_seg_scan_display_if.sv | 25 ++
 rtl/seven_seg_scan_display.sv | 219 +++++++++++++++++++++
 tb/tb_seven_seg_scan_display.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scan_display_if.sv
// Bus between the ALU result path and the scanned 7-segment display:
// load strobe with operand and format flags, status flags and the board pins.
interface seven_seg_scan_display_if #(
  parameter int DATA_W   = 12,
  parameter int N_DIGITS = 4
);
  logic [DATA_W-1:0]   value;
  logic                is_signed;
  logic                blank;
  logic                load;
  logic                busy;
  logic                overflow;
  logic [N_DIGITS-1:0] an;
  logic [6:0]          sseg;

  modport master (
    output value, is_signed, blank, load,
    input  busy, overflow, an, sseg
  );

  modport slave (
    input  value, is_signed, blank, load,
    output busy, overflow, an, sseg
  );
endinterface

// File: rtl/seven_seg_scan_display.sv
// Binary-to-BCD (sequential double-dabble) converter feeding a time-multiplexed
// N-digit 7-segment display with sign, leading-zero blanking and overflow 'E'.
module seven_seg_scan_display #(
  parameter int DIV_COUNT      = 50_000,
  parameter int N_DIGITS       = 4,
  parameter int DATA_W         = 12,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input logic                     clk,
  input logic                     rst,
  seven_seg_scan_display_if.slave bus
);

  localparam int CONV_DIGITS = (DATA_W + 2) / 3;
  localparam int BCD_W       = CONV_DIGITS * 4;
  localparam int EXT_DIGITS  = (CONV_DIGITS > N_DIGITS) ? CONV_DIGITS : N_DIGITS;
  localparam int CNT_W       = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
  localparam int IDX_W       = $clog2(N_DIGITS);
  localparam int BIT_W       = $clog2(DATA_W);
  localparam int NEED_W      = $clog2(EXT_DIGITS + 2);
  localparam int CMP_W       = (IDX_W > NEED_W) ? IDX_W : NEED_W;
  localparam logic POL       = (SEG_ACTIVE_LOW != 0);

  // Active-high {g,f,e,d,c,b,a} glyphs
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_MINUS = 7'b1000000;
  localparam logic [6:0] SEG_E     = 7'b1111001;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  function automatic logic [6:0] font(input logic [3:0] d);
    logic [6:0] f;
    case (d)
      4'd0:    f = 7'b0111111;
      4'd1:    f = 7'b0000110;
      4'd2:    f = 7'b1011011;
      4'd3:    f = 7'b1001111;
      4'd4:    f = 7'b1100110;
      4'd5:    f = 7'b1101101;
      4'd6:    f = 7'b1111101;
      4'd7:    f = 7'b0000111;
      4'd8:    f = 7'b1111111;
      4'd9:    f = 7'b1101111;
      default: f = 7'b0000000;
    endcase
    return f;
  endfunction

  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < CONV_DIGITS; i++) begin
      r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? (b[i*4 +: 4] + 4'd3) : b[i*4 +: 4];
    end
    return r;
  endfunction

  state_t                  state_r;
  logic [DATA_W-1:0]       mag_r;
  logic [BCD_W-1:0]        bcd_r;
  logic [BIT_W-1:0]        bit_cnt_r;
  logic                    neg_r;
  logic                    blank_r;
  logic                    busy_r;

  logic [N_DIGITS*4-1:0]   disp_digits_r;
  logic                    disp_neg_r;
  logic                    disp_blank_r;
  logic                    disp_ovf_r;
  logic [NEED_W-1:0]       disp_need_r;

  logic [CNT_W-1:0]        tick_r;
  logic [IDX_W-1:0]        idx_r;
  logic [N_DIGITS-1:0]     an_r;
  logic [6:0]              sseg_r;

  logic [BCD_W-1:0]        bcd_adj_s;
  logic [EXT_DIGITS*4-1:0] bcd_ext_s;
  logic [NEED_W-1:0]       need_s;
  logic                    ovf_s;
  logic                    neg_in_s;
  logic [3:0]              digit_s;
  logic [CMP_W-1:0]        pos_s;
  logic [CMP_W-1:0]        need_cmp_s;
  logic                    is_top_s;
  logic [6:0]              seg_hi_s;
  logic [N_DIGITS-1:0]     an_hi_s;

  // Conversion datapath: next BCD step, significant-digit count and overflow
  always_comb begin
    neg_in_s  = bus.is_signed & bus.value[DATA_W-1];
    bcd_adj_s = dd_adjust(bcd_r);
    bcd_ext_s = (EXT_DIGITS*4)'(bcd_r);
    need_s    = NEED_W'(1);
    for (int i = 1; i < CONV_DIGITS; i++) begin
      need_s = (bcd_r[i*4 +: 4] != 4'd0) ? NEED_W'(i + 1) : need_s;
    end
    ovf_s = ({1'b0, need_s} + (NEED_W+1)'(neg_r)) > (NEED_W+1)'(N_DIGITS);
  end

  // Load/convert/commit sequencer; the display register only changes at COMMIT
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      mag_r         <= '0;
      bcd_r         <= '0;
      bit_cnt_r     <= '0;
      neg_r         <= 1'b0;
      blank_r       <= 1'b0;
      busy_r        <= 1'b0;
      disp_digits_r <= '0;
      disp_neg_r    <= 1'b0;
      disp_blank_r  <= 1'b0;
      disp_ovf_r    <= 1'b0;
      disp_need_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.load) begin
            neg_r     <= neg_in_s;
            blank_r   <= bus.blank;
            mag_r     <= neg_in_s ? (~bus.value + DATA_W'(1)) : bus.value;
            bcd_r     <= '0;
            bit_cnt_r <= '0;
            busy_r    <= 1'b1;
            state_r   <= CONV;
          end
        end
        CONV: begin
          bcd_r     <= {bcd_adj_s[BCD_W-2:0], mag_r[DATA_W-1]};
          mag_r     <= {mag_r[DATA_W-2:0], 1'b0};
          bit_cnt_r <= bit_cnt_r + BIT_W'(1);
          if (bit_cnt_r == BIT_W'(DATA_W - 1)) begin
            state_r <= COMMIT;
          end
        end
        COMMIT: begin
          disp_digits_r <= bcd_ext_s[N_DIGITS*4-1:0];
          disp_neg_r    <= neg_r;
          disp_blank_r  <= blank_r;
          disp_ovf_r    <= ovf_s;
          disp_need_r   <= need_s;
          busy_r        <= 1'b0;
          state_r       <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Scan timebase: index advances on the cycle after the divider reaches its top
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_r <= '0;
      idx_r  <= '0;
    end else if (tick_r == CNT_W'(DIV_COUNT - 1)) begin
      tick_r <= '0;
      idx_r  <= (idx_r == IDX_W'(N_DIGITS - 1)) ? '0 : (idx_r + IDX_W'(1));
    end else begin
      tick_r <= tick_r + CNT_W'(1);
    end
  end

  // Glyph for the digit currently being scanned
  always_comb begin
    digit_s = 4'd0;
    for (int i = 0; i < N_DIGITS; i++) begin
      digit_s = (idx_r == IDX_W'(i)) ? disp_digits_r[i*4 +: 4] : digit_s;
    end
    pos_s      = CMP_W'(idx_r);
    need_cmp_s = CMP_W'(disp_need_r);
    is_top_s   = (idx_r == IDX_W'(N_DIGITS - 1));
    an_hi_s    = N_DIGITS'(1) << idx_r;
    if (disp_ovf_r) begin
      seg_hi_s = SEG_E;
    end else if (idx_r == '0) begin
      seg_hi_s = font(digit_s);
    end else if (disp_blank_r) begin
      // Sign sits immediately left of the most significant shown digit
      if (pos_s < need_cmp_s) begin
        seg_hi_s = font(digit_s);
      end else if ((pos_s == need_cmp_s) && disp_neg_r) begin
        seg_hi_s = SEG_MINUS;
      end else begin
        seg_hi_s = SEG_BLANK;
      end
    end else begin
      if (disp_neg_r && is_top_s) begin
        seg_hi_s = SEG_MINUS;
      end else begin
        seg_hi_s = font(digit_s);
      end
    end
  end

  // Registered pin drivers with board polarity applied
  always_ff @(posedge clk) begin
    if (rst) begin
      an_r   <= {N_DIGITS{POL}};
      sseg_r <= {7{POL}};
    end else begin
      an_r   <= an_hi_s ^ {N_DIGITS{POL}};
      sseg_r <= seg_hi_s ^ {7{POL}};
    end
  end

  assign bus.an       = an_r;
  assign bus.sseg     = sseg_r;
  assign bus.busy     = busy_r;
  assign bus.overflow = disp_ovf_r;

endmodule

// File: tb/tb_seven_seg_scan_display.sv
// Randomised and directed bench for seven_seg_scan_display against a decimal
// arithmetic reference model; a second DIV_COUNT=1 instance checks fast scanning.
module tb_seven_seg_scan_display;

  localparam int D = 4;
  localparam int N = 4;
  localparam int W = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   n_edges = 0;

  logic [6:0] exp_seg [N];
  logic       exp_ovf;

  always #5 clk = ~clk;

  seven_seg_scan_display_if #(.DATA_W(W), .N_DIGITS(N)) ifc ();
  seven_seg_scan_display_if #(.DATA_W(W), .N_DIGITS(N)) ifc1 ();

  seven_seg_scan_display #(
    .DIV_COUNT(D), .N_DIGITS(N), .DATA_W(W), .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .bus(ifc)
  );

  seven_seg_scan_display #(
    .DIV_COUNT(1), .N_DIGITS(N), .DATA_W(W), .SEG_ACTIVE_LOW(1)
  ) dut1 (
    .clk(clk), .rst(rst), .bus(ifc1)
  );

  // Edges since reset release: scan position follows from this alone
  always @(posedge clk) begin
    if (rst) n_edges <= 0;
    else     n_edges <= n_edges + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] font_hi(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Expected glyph per position from decimal arithmetic on the operand
  task automatic model(input logic [11:0] v, input logic s, input logic b);
    int val, mag, need, t, div;
    bit neg;
    val  = (s && v[11]) ? int'(v) - 4096 : int'(v);
    neg  = (val < 0);
    mag  = neg ? -val : val;
    need = 1;
    t    = mag / 10;
    while (t > 0) begin
      need++;
      t = t / 10;
    end
    exp_ovf = ((need + int'(neg)) > N);
    div = 1;
    for (int p = 0; p < N; p++) begin
      int dg;
      logic [6:0] hi;
      dg = (mag / div) % 10;
      div = div * 10;
      if (exp_ovf)                     hi = 7'b1111001;
      else if (b && p >= need)         hi = (neg && p == need) ? 7'b1000000 : 7'b0000000;
      else if (!b && neg && p == N-1)  hi = 7'b1000000;
      else                             hi = font_hi(dg);
      exp_seg[p] = ~hi;
    end
  endtask

  task automatic scan_window(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) begin
      int idx;
      logic [3:0] ea;
      idx = ((n_edges - 1) / D) % N;
      ea  = ~(4'b0001 << idx);
      chk({tag, "_an"}, 32'(ifc.an), 32'(ea));
      chk({tag, "_seg"}, 32'(ifc.sseg), 32'(exp_seg[idx]));
      chk({tag, "_ovf"}, 32'(ifc.overflow), 32'(exp_ovf));
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (ifc.busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic load_and_show(input logic [11:0] v, input logic s, input logic b, input string tag);
    int cnt;
    ifc.value = v; ifc.is_signed = s; ifc.blank = b; ifc.load = 1'b1;
    @(negedge clk);
    ifc.load = 1'b0;
    wait_idle(cnt);
    chk({tag, "_busy_len"}, 32'(cnt), 32'(W + 1));
    model(v, s, b);
    @(negedge clk);
    scan_window(N * D, tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_an"}, 32'(ifc.an), 32'h0000_000F);
    chk({tag, "_seg"}, 32'(ifc.sseg), 32'h0000_007F);
    chk({tag, "_busy"}, 32'(ifc.busy), 32'h0);
    chk({tag, "_ovf"}, 32'(ifc.overflow), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int cnt;
    ifc.value = '0;  ifc.is_signed = 1'b0; ifc.blank = 1'b0; ifc.load = 1'b0;
    ifc1.value = '0; ifc1.is_signed = 1'b0; ifc1.blank = 1'b0; ifc1.load = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    chk("rst1_an", 32'(ifc1.an), 32'h0000_000F);
    rst = 1'b0;
    @(negedge clk);

    // Fast-scan instance: a new digit every clock, wrapping 3 -> 0
    for (int i = 0; i < 9; i++) begin
      logic [3:0] ea;
      ea = ~(4'b0001 << ((n_edges - 1) % N));
      chk("fast_an", 32'(ifc1.an), 32'(ea));
      chk("fast_seg", 32'(ifc1.sseg), 32'h0000_0040);
      @(negedge clk);
    end

    model(12'd0, 1'b0, 1'b0);
    scan_window(N * D, "zero");

    load_and_show(12'd1234, 1'b0, 1'b0, "t1");
    load_and_show(12'hF85,  1'b1, 1'b1, "t2");
    load_and_show(12'hFFB,  1'b1, 1'b1, "t3");
    load_and_show(12'h800,  1'b1, 1'b0, "t4a");
    load_and_show(12'd7,    1'b0, 1'b0, "t4b");
    load_and_show(12'd4095, 1'b0, 1'b1, "max");
    load_and_show(12'h7FF,  1'b1, 1'b0, "pmax");

    // Load during a conversion is ignored
    ifc.value = 12'd999; ifc.is_signed = 1'b0; ifc.blank = 1'b0; ifc.load = 1'b1;
    @(negedge clk);
    ifc.load = 1'b0;
    repeat (3) @(negedge clk);
    ifc.value = 12'd42; ifc.load = 1'b1;
    @(negedge clk);
    ifc.load = 1'b0;
    wait_idle(cnt);
    chk("t5_idle", 32'(cnt < 100), 32'h1);
    model(12'd999, 1'b0, 1'b0);
    @(negedge clk);
    scan_window(N * D, "t5");

    // Reset in mid-conversion aborts it and clears the display
    ifc.value = 12'd1234; ifc.load = 1'b1;
    @(negedge clk);
    ifc.load = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    ifc.value = 12'd555; ifc.load = 1'b1;
    @(negedge clk);
    ifc.load = 1'b0;
    check_reset_outputs("t5rst");
    rst = 1'b0;
    @(negedge clk);
    chk("t5rst_busy_after", 32'(ifc.busy), 32'h0);
    model(12'd0, 1'b0, 1'b0);
    scan_window(N * D, "t5z");

    for (int r = 0; r < 8; r++) begin
      logic [11:0] v;
      logic s, b;
      v = 12'($urandom_range(0, 4095));
      s = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      load_and_show(v, s, b, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
